// File: rtl/shift_register_pkg.sv
// -----------------------------------------------------------------------------
// shift_register_pkg
//   Shared constants for the parallel-load / serial-in shift register.
//   - WIDTH_DEFAULT : default register width in bits.
//   - DIR_LEFT      : DIR encoding for a shift toward the MSB (SER_IN -> LSB).
//   - DIR_RIGHT     : DIR encoding for a shift toward the LSB (SER_IN -> MSB).
// -----------------------------------------------------------------------------
package shift_register_pkg;

   localparam int   WIDTH_DEFAULT = 8;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;

endpackage : shift_register_pkg

// File: rtl/shift_register.sv
// -----------------------------------------------------------------------------
// shift_register
//   Edge-triggered parallel-load / serial-in shift register with a synchronous
//   clear, a synchronous parallel load and a one-bit left or right shift per
//   clock. The vacated bit is filled from SER_IN; the bit shifted out is
//   discarded.
//
// Ports
//   CLK     in   1      clock, all state changes on the rising edge
//   RST     in   1      synchronous active-high clear (highest priority)
//   LOAD    in   1      synchronous parallel load, overrides SHIFT
//   SHIFT   in   1      synchronous one-bit shift enable
//   DIR     in   1      DIR_LEFT (1) toward MSB, DIR_RIGHT (0) toward LSB
//   DATA    in   WIDTH  parallel load value
//   SER_IN  in   1      serial fill bit for shifts
//   Q       out  WIDTH  register contents, driven straight from the flops
// -----------------------------------------------------------------------------
module shift_register
   import shift_register_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             LOAD,
   input  logic             SHIFT,
   input  logic             DIR,
   input  logic [WIDTH-1:0] DATA,
   input  logic             SER_IN,
   output logic [WIDTH-1:0] Q
);

   logic [WIDTH-1:0] q_next;

   // Next-state mux. A priority if/else chain (rather than a case on the
   // control bits) means an unknown SHIFT is never consulted while LOAD is
   // high, so it cannot corrupt the loaded value. RST is applied in the
   // register itself, above everything here.
   always_comb begin
      q_next = Q;
      if (LOAD) begin
         q_next = DATA;
      end else if (SHIFT) begin
         if (DIR == DIR_LEFT) begin
            q_next = {Q[WIDTH-2:0], SER_IN};
         end else begin
            q_next = {SER_IN, Q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         Q <= '0;
      end else begin
         Q <= q_next;
      end
   end

endmodule : shift_register

// File: tb/tb_shift_register.sv
// -----------------------------------------------------------------------------
// tb_shift_register
//   Directed bench for shift_register (WIDTH = 8). Each scenario task drives
//   its stimulus, advances the clock and compares Q against hand-computed
//   values. Inputs change 1 ns after a rising edge; Q is sampled at that same
//   point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_shift_register;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         load;
   logic         shift;
   logic         dir;
   logic [W-1:0] data;
   logic         ser_in;
   logic [W-1:0] q;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];

   shift_register #(.WIDTH(W)) dut (
      .CLK    (clk),
      .RST    (rst),
      .LOAD   (load),
      .SHIFT  (shift),
      .DIR    (dir),
      .DATA   (data),
      .SER_IN (ser_in),
      .Q      (q)
   );

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 ns before sampling/driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst    = 1'b0;
      load   = 1'b0;
      shift  = 1'b0;
      dir    = 1'b0;
      data   = '0;
      ser_in = 1'b0;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (q !== 8'h00) begin
            errors++;
            $display("FAIL reset edge%0d q=%h exp=%h", i, q, 8'h00);
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (q !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold edge%0d q=%h exp=%h", i, q, 8'h00);
         end
      end
   endtask

   task automatic test_load_hold();
      load = 1'b1;
      data = 8'h55;
      tick();
      checks++;
      if (q !== 8'h55) begin
         errors++;
         $display("FAIL load q=%h exp=%h", q, 8'h55);
      end
      // DIR, SER_IN and DATA wiggle while idle; Q must hold.
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         dir    = i[0];
         ser_in = ~i[0];
         data   = 8'hC0 | 8'(i);
         tick();
         checks++;
         if (q !== 8'h55) begin
            errors++;
            $display("FAIL load_hold edge%0d q=%h exp=%h", i, q, 8'h55);
         end
      end
   endtask

   task automatic test_shift_left();
      logic [W-1:0] e;
      exp_q = {8'hAA, 8'h54, 8'hA8, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00,
               8'h01, 8'h03};
      shift  = 1'b1;
      dir    = 1'b1;
      ser_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 8) ser_in = 1'b1;
         tick();
         e = exp_q.pop_front();
         checks++;
         if (q !== e) begin
            errors++;
            $display("FAIL shift_left edge%0d q=%h exp=%h", i, q, e);
         end
      end
      shift = 1'b0;
   endtask

   task automatic test_shift_right();
      logic [W-1:0] e;
      load = 1'b1;
      data = 8'hFF;
      tick();
      checks++;
      if (q !== 8'hFF) begin
         errors++;
         $display("FAIL right_load q=%h exp=%h", q, 8'hFF);
      end
      load   = 1'b0;
      exp_q  = {8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
      shift  = 1'b1;
      dir    = 1'b0;
      ser_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if (q !== e) begin
            errors++;
            $display("FAIL shift_right edge%0d q=%h exp=%h", i, q, e);
         end
      end
      shift = 1'b0;
      tick();
      checks++;
      if (q !== 8'h00) begin
         errors++;
         $display("FAIL right_hold q=%h exp=%h", q, 8'h00);
      end
   endtask

   task automatic test_priority();
      // Seed a non-zero value so the clear is observable.
      load = 1'b1;
      data = 8'hA5;
      tick();
      checks++;
      if (q !== 8'hA5) begin
         errors++;
         $display("FAIL prio_seed q=%h exp=%h", q, 8'hA5);
      end

      // RST beats LOAD and SHIFT.
      rst    = 1'b1;
      load   = 1'b1;
      shift  = 1'b1;
      dir    = 1'b1;
      ser_in = 1'b1;
      data   = 8'h99;
      tick();
      checks++;
      if (q !== 8'h00) begin
         errors++;
         $display("FAIL prio_rst q=%h exp=%h", q, 8'h00);
      end

      // LOAD beats SHIFT; no shift applied on top of the load.
      rst  = 1'b0;
      data = 8'h3C;
      tick();
      checks++;
      if (q !== 8'h3C) begin
         errors++;
         $display("FAIL prio_load q=%h exp=%h", q, 8'h3C);
      end

      // Unknown SHIFT while LOAD is high must not disturb the load.
      shift = 1'bx;
      data  = 8'hC3;
      tick();
      checks++;
      if (q !== 8'hC3) begin
         errors++;
         $display("FAIL prio_load_xshift q=%h exp=%h", q, 8'hC3);
      end

      // Shift run from C3, left with SER_IN=1: 87, 0F.
      load  = 1'b0;
      shift = 1'b1;
      tick();
      checks++;
      if (q !== 8'h87) begin
         errors++;
         $display("FAIL prio_run0 q=%h exp=%h", q, 8'h87);
      end
      tick();
      checks++;
      if (q !== 8'h0F) begin
         errors++;
         $display("FAIL prio_run1 q=%h exp=%h", q, 8'h0F);
      end

      // RST mid-run clears at the next edge.
      rst = 1'b1;
      tick();
      checks++;
      if (q !== 8'h00) begin
         errors++;
         $display("FAIL prio_midrst q=%h exp=%h", q, 8'h00);
      end

      // Shifting resumes from zero.
      rst = 1'b0;
      tick();
      checks++;
      if (q !== 8'h01) begin
         errors++;
         $display("FAIL prio_resume q=%h exp=%h", q, 8'h01);
      end
      shift = 1'b0;
   endtask

   task automatic test_right_fill();
      logic [W-1:0] model;
      rst = 1'b1;
      tick();
      checks++;
      if (q !== 8'h00) begin
         errors++;
         $display("FAIL fill_clear q=%h exp=%h", q, 8'h00);
      end
      rst    = 1'b0;
      model  = 8'h00;
      shift  = 1'b1;
      dir    = 1'b0;
      ser_in = 1'b1;
      for (int i = 0; i < W; i++) begin
         tick();
         model = {ser_in, model[W-1:1]};
         checks++;
         if (q !== model) begin
            errors++;
            $display("FAIL right_fill edge%0d q=%h exp=%h", i, q, model);
         end
      end
      checks++;
      if (q !== 8'hFF) begin
         errors++;
         $display("FAIL right_fill_final q=%h exp=%h", q, 8'hFF);
      end
      shift = 1'b0;
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      idle_inputs();
      test_reset();
      test_load_hold();
      test_shift_left();
      test_shift_right();
      test_priority();
      test_right_fill();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_shift_register
